axis_pattern_source: RTL and testbench

Parametrised AXI4-Stream test-pattern source, successor to the fixed counter generator. Emits beats at a runtime-programmable rate in one of four patterns: counter with configurable start/end/step, walking-one, 32-bit LFSR, or constant. It frames beats into packets with `tlast` and counts rate ticks lost to backpressure. It sits at the head of stream datapaths for bring-up, throughput and integrity tests.

---
 rtl/axis_pattern_source.sv | 151 +++++++++++++++
 tb/tb_axis_pattern_source.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pattern_source.sv
// AXI4-Stream test-pattern source: counter, walking-one, 32-bit LFSR or constant beats
// emitted at a programmable tick rate, framed into packets, with a dropped-tick counter.
module axis_pattern_source #(
   parameter int unsigned TDATA_WIDTH = 32,
   parameter int unsigned DIV_WIDTH   = 16,
   parameter int unsigned PKT_WIDTH   = 16,
   parameter logic [31:0] LFSR_SEED   = 32'h0000_0001
) (
   input  logic                   m_axis_aclk,
   input  logic                   m_axis_aresetn,
   input  logic                   enable,
   input  logic [1:0]             cfg_mode,
   input  logic [TDATA_WIDTH-1:0] cfg_start,
   input  logic [TDATA_WIDTH-1:0] cfg_end,
   input  logic [TDATA_WIDTH-1:0] cfg_incr,
   input  logic [DIV_WIDTH-1:0]   cfg_div,
   input  logic [PKT_WIDTH-1:0]   cfg_pkt_len,
   input  logic                   sts_clear,
   input  logic                   m_axis_tready,
   output logic [TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                   m_axis_tvalid,
   output logic                   m_axis_tlast,
   output logic [15:0]            sts_missed
);

   localparam logic [31:0] LfsrMask = 32'h8020_0003;

   logic [1:0]             mode_q, mode_d;
   logic [TDATA_WIDTH-1:0] cnt_q, cnt_d;
   logic [TDATA_WIDTH-1:0] walk_q, walk_d;
   logic [31:0]            lfsr_q, lfsr_d;
   logic [PKT_WIDTH-1:0]   idx_q, idx_d;
   logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
   logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
   logic                   tvalid_q, tvalid_d;
   logic                   tlast_q, tlast_d;
   logic [15:0]            missed_q, missed_d;
   // Set only straight out of reset so the counter presents cfg_start before any idle load.
   logic                   init_q;

   logic                   tick, slot_free, load, drop, pkt_end;
   logic [TDATA_WIDTH-1:0] cnt_cur, lfsr_wide, pat;

   assign tick      = enable && (div_cnt_q >= cfg_div);
   assign slot_free = !tvalid_q || m_axis_tready;
   assign load      = tick && slot_free;
   assign drop      = tick && !slot_free;
   assign pkt_end   = (idx_q == cfg_pkt_len);
   assign cnt_cur   = init_q ? cfg_start : cnt_q;

   always_comb begin
      lfsr_wide = '0;
      for (int i = 0; i < TDATA_WIDTH; i++) begin
         lfsr_wide[i] = lfsr_q[i[4:0]];
      end
   end

   always_comb begin
      pat = '0;
      case (mode_q)
         2'd0:    pat = cnt_cur;
         2'd1:    pat = walk_q;
         2'd2:    pat = lfsr_wide;
         default: pat = cfg_start;
      endcase
   end

   always_comb begin
      mode_d    = mode_q;
      cnt_d     = cnt_cur;
      walk_d    = walk_q;
      lfsr_d    = lfsr_q;
      idx_d     = idx_q;
      div_cnt_d = div_cnt_q;
      tdata_d   = tdata_q;
      tvalid_d  = tvalid_q;
      tlast_d   = tlast_q;
      missed_d  = missed_q;

      if (!enable || tick) begin
         div_cnt_d = '0;
      end else begin
         div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
      end

      if (load) begin
         tdata_d  = pat;
         tlast_d  = pkt_end;
         idx_d    = pkt_end ? '0 : idx_q + PKT_WIDTH'(1);
         tvalid_d = 1'b1;
         case (mode_q)
            2'd0:    cnt_d  = (cnt_cur >= cfg_end) ? cfg_start : cnt_cur + cfg_incr;
            2'd1:    walk_d = {walk_q[TDATA_WIDTH-2:0], walk_q[TDATA_WIDTH-1]};
            2'd2:    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrMask : 32'h0);
            default: ;
         endcase
      end else if (tvalid_q && m_axis_tready) begin
         tvalid_d = 1'b0;
      end

      // A pending beat blocks idle load, so dropping enable never withdraws it.
      if (!enable && !tvalid_q) begin
         mode_d    = cfg_mode;
         cnt_d     = cfg_start;
         walk_d    = TDATA_WIDTH'(1);
         lfsr_d    = LFSR_SEED;
         idx_d     = '0;
         div_cnt_d = '0;
      end

      if (sts_clear) begin
         missed_d = '0;
      end else if (drop && (missed_q != 16'hFFFF)) begin
         missed_d = missed_q + 16'd1;
      end
   end

   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         mode_q    <= 2'd0;
         cnt_q     <= '0;
         walk_q    <= TDATA_WIDTH'(1);
         lfsr_q    <= LFSR_SEED;
         idx_q     <= '0;
         div_cnt_q <= '0;
         tdata_q   <= '0;
         tvalid_q  <= 1'b0;
         tlast_q   <= 1'b0;
         missed_q  <= '0;
         init_q    <= 1'b1;
      end else begin
         mode_q    <= mode_d;
         cnt_q     <= cnt_d;
         walk_q    <= walk_d;
         lfsr_q    <= lfsr_d;
         idx_q     <= idx_d;
         div_cnt_q <= div_cnt_d;
         tdata_q   <= tdata_d;
         tvalid_q  <= tvalid_d;
         tlast_q   <= tlast_d;
         missed_q  <= missed_d;
         init_q    <= 1'b0;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign sts_missed    = missed_q;

endmodule

// File: tb/tb_axis_pattern_source.sv
// Directed bench for axis_pattern_source: a 32-bit and an 8-bit instance share all inputs.
module tb_axis_pattern_source;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [1:0]  cfg_mode;
   logic [31:0] cfg_start, cfg_end, cfg_incr;
   logic [15:0] cfg_div, cfg_pkt_len;
   logic        sts_clear;
   logic        tready;

   logic [31:0] d32;
   logic        v32, l32;
   logic [15:0] m32;
   logic [7:0]  d8;
   logic        v8, l8;
   logic [15:0] m8;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] cnt_seq [4] = '{32'd250, 32'd252, 32'd254, 32'd256};
   logic [31:0] lf;
   logic [7:0]  w;
   int          lf_bad, lf_zero;

   always #5 clk = ~clk;

   axis_pattern_source #(.TDATA_WIDTH(32)) dut32 (
      .m_axis_aclk(clk), .m_axis_aresetn(rst_n), .enable(enable), .cfg_mode(cfg_mode),
      .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_incr(cfg_incr), .cfg_div(cfg_div),
      .cfg_pkt_len(cfg_pkt_len), .sts_clear(sts_clear), .m_axis_tready(tready),
      .m_axis_tdata(d32), .m_axis_tvalid(v32), .m_axis_tlast(l32), .sts_missed(m32)
   );

   axis_pattern_source #(.TDATA_WIDTH(8)) dut8 (
      .m_axis_aclk(clk), .m_axis_aresetn(rst_n), .enable(enable), .cfg_mode(cfg_mode),
      .cfg_start(cfg_start[7:0]), .cfg_end(cfg_end[7:0]), .cfg_incr(cfg_incr[7:0]),
      .cfg_div(cfg_div), .cfg_pkt_len(cfg_pkt_len), .sts_clear(sts_clear),
      .m_axis_tready(tready), .m_axis_tdata(d8), .m_axis_tvalid(v8), .m_axis_tlast(l8),
      .sts_missed(m8)
   );

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; cfg_mode = 2'd0; cfg_start = '0; cfg_end = '0;
      cfg_incr = '0; cfg_div = '0; cfg_pkt_len = '0; sts_clear = 1'b0; tready = 1'b0;
      step(3);
      chk("rst_valid", 64'(v32), 64'(0));
      chk("rst_data", 64'(d32), 64'(0));
      chk("rst_last", 64'(l32), 64'(0));
      chk("rst_missed", 64'(m32), 64'(0));
      rst_n = 1'b1;
      step();

      // Counter wrap, back-to-back beats
      cfg_mode = 2'd0; cfg_start = 32'd250; cfg_end = 32'd255; cfg_incr = 32'd2;
      cfg_div = 16'd0; cfg_pkt_len = 16'd3; tready = 1'b1;
      step();
      enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("cnt_valid", 64'(v32), 64'(1));
         chk("cnt_data", 64'(d32), 64'(cnt_seq[i % 4]));
         chk("cnt_last", 64'(l32), 64'((i % 4) == 3));
      end
      enable = 1'b0;
      step(2);
      chk("cnt_stop", 64'(v32), 64'(0));

      // Rate divider: one beat per 5 cycles
      cfg_start = 32'd0; cfg_incr = 32'd1; cfg_div = 16'd4;
      step();
      enable = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         step();
         if (c % 5 == 0) begin
            chk("div_valid", 64'(v32), 64'(1));
            chk("div_data", 64'(d32), 64'(c / 5 - 1));
         end else begin
            chk("div_idle", 64'(v32), 64'(0));
         end
      end
      chk("div_missed", 64'(m32), 64'(0));
      enable = 1'b0;
      step(2);

      // Lowering cfg_div below div_cnt ticks on the next cycle
      cfg_div = 16'd10;
      step();
      enable = 1'b1;
      step(4);
      chk("divlow_pre", 64'(v32), 64'(0));
      cfg_div = 16'd2;
      step();
      chk("divlow_tick", 64'(v32), 64'(1));
      chk("divlow_data", 64'(d32), 64'(0));
      enable = 1'b0; cfg_div = 16'd0;
      step(2);

      // Backpressure hold and dropped ticks
      tready = 1'b0;
      enable = 1'b1;
      step();
      chk("bp_first_valid", 64'(v32), 64'(1));
      chk("bp_first_data", 64'(d32), 64'(0));
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_hold_valid", 64'(v32), 64'(1));
         chk("bp_hold_data", 64'(d32), 64'(0));
         chk("bp_hold_last", 64'(l32), 64'(0));
      end
      chk("bp_missed", 64'(m32), 64'(10));
      tready = 1'b1;
      step();
      chk("bp_next_valid", 64'(v32), 64'(1));
      chk("bp_next_data", 64'(d32), 64'(1));
      enable = 1'b0;
      step(2);
      sts_clear = 1'b1;
      step();
      sts_clear = 1'b0;
      chk("bp_clear", 64'(m32), 64'(0));

      // Walking-one on the 8-bit instance
      cfg_mode = 2'd1;
      step();
      enable = 1'b1;
      w = 8'h01;
      for (int i = 0; i < 9; i++) begin
         step();
         chk("walk_data", 64'(d8), 64'(w));
         w = {w[6:0], w[7]};
      end
      enable = 1'b0;
      step(2);

      // LFSR: 8-bit first outputs, 32-bit state against a model, never all-zero
      cfg_mode = 2'd2;
      step();
      enable = 1'b1;
      lf = 32'h1; lf_bad = 0; lf_zero = 0;
      for (int n = 0; n < 10000; n++) begin
         step();
         if (n == 0) chk("lfsr8_first", 64'(d8), 64'(8'h01));
         if (n == 1) chk("lfsr8_second", 64'(d8), 64'(8'h03));
         if (d32 !== lf) lf_bad++;
         if (d32 == 32'h0) lf_zero++;
         lf = (lf >> 1) ^ (lf[0] ? 32'h8020_0003 : 32'h0);
      end
      chk("lfsr_model", 64'(lf_bad), 64'(0));
      chk("lfsr_nonzero", 64'(lf_zero), 64'(0));
      enable = 1'b0;
      step(2);

      // Constant mode after a mode switch through idle
      cfg_mode = 2'd3; cfg_start = 32'h0000_00A5;
      step();
      enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("const_data8", 64'(d8), 64'(8'hA5));
         chk("const_data32", 64'(d32), 64'(32'hA5));
      end

      // Dropping enable with a pending beat: it completes, then nothing more
      enable = 1'b0; tready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("pend_valid", 64'(v32), 64'(1));
         chk("pend_data", 64'(d32), 64'(32'hA5));
      end
      tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("pend_done", 64'(v32), 64'(0));
      end

      // Asynchronous reset between clock edges
      enable = 1'b1;
      step(3);
      chk("arst_pre", 64'(v32), 64'(1));
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(v32), 64'(0));
      chk("arst_data32", 64'(d32), 64'(0));
      chk("arst_data8", 64'(d8), 64'(0));
      chk("arst_last", 64'(l32), 64'(0));
      enable = 1'b0;
      step();
      rst_n = 1'b1;

      // Packet framing restarts at index 0 after reset
      cfg_mode = 2'd0; cfg_start = 32'd0; cfg_end = 32'd255; cfg_incr = 32'd1;
      cfg_pkt_len = 16'd3;
      step();
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_rst_data", 64'(d32), 64'(i));
         chk("post_rst_last", 64'(l32), 64'(i == 3));
      end

      // Saturation of the dropped-tick counter, then clear beats a same-cycle drop
      tready = 1'b0;
      step(70000);
      chk("sat_missed32", 64'(m32), 64'(16'hFFFF));
      chk("sat_missed8", 64'(m8), 64'(16'hFFFF));
      sts_clear = 1'b1;
      step();
      chk("clear_prio", 64'(m32), 64'(0));
      sts_clear = 1'b0;
      step();
      chk("count_resume", 64'(m32), 64'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
